vga_scan_controller: RTL and testbench
======================================

Name: vga_scan_controller

Overview:
Pixel-side master of the draw interface. It generates the raster coordinates pixelX/pixelY that all object drawers (letters, ball, flippers, score) decode. It samples the prioritised drawRequest/RGB returned by the object mux one DRAW_LATENCY later and drives a 640x480@60 VGA port: hSync, vSync, blankN and 8-bit RGB, all aligned.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hSync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vSync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
DRAW_LATENCY, 1, cycles between pixelX/Y change and the matching drawRequest/RGBIn (drawers register once); legal range 1..4

Ports:
clk  in  1  pixel clock (25.175 MHz nominal)
resetN  in  1  asynchronous, active-low reset
pixelX  out  11  current horizontal counter, 0..H_TOTAL-1
pixelY  out  11  current vertical counter, 0..V_TOTAL-1
drawRequest  in  1  object mux asserts "pixel is owned", DRAW_LATENCY cycles after pixelX/Y
RGBIn  in  8  colour from object mux (RRRGGGBB), same timing as drawRequest
startOfFrame  out  1  one-cycle pulse, game-logic update strobe
hSync  out  1  active-low horizontal sync
vSync  out  1  active-low vertical sync
blankN  out  1  high during visible area
vgaRGB  out  8  colour to DAC

Behaviour:
- Reset, asynchronous on resetN low: hCount=0, vCount=0, hSync=1, vSync=1, blankN=0, vgaRGB=0, startOfFrame=0, delay-line contents cleared to the inactive values (sync=1, visible=0).
- H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL=V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- hCount increments every clk. At H_TOTAL-1 it wraps to 0 and vCount increments. vCount wraps from V_TOTAL-1 to 0 on the same edge as the hCount wrap.
- pixelX=hCount and pixelY=vCount, driven directly from the counter registers. They are also driven during blanking; drawers rely on their own range checks.
- Raw timing decodes, combinational from the counters:
  - visible = hCount<H_VISIBLE && vCount<V_VISIBLE
  - hSyncRaw low for hCount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. 656..751
  - vSyncRaw low for vCount in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. 490..491, for whole lines
- Alignment:
  - hSyncRaw, vSyncRaw and visible pass through a DRAW_LATENCY-deep shift register, so they arrive together with drawRequest/RGBIn.
  - One output register stage follows. Total latency from counter value to hSync/vSync/blankN/vgaRGB is DRAW_LATENCY+1 cycles.
- Colour select, at the output register input:
  - visibleD=0 gives 0.
  - Otherwise, drawRequest=1 and RGBIn!=COLOR_TRANSPARENT gives RGBIn.
  - Otherwise, COLOR_BACKGROUND.
- startOfFrame is registered and is 1 exactly for the cycle after the counters read (0,0), i.e. once per 420000 cycles. It is not delayed by DRAW_LATENCY.
- First cycle after reset release: counters at (0,0). startOfFrame pulses on the next cycle.
- Reset mid-frame: all outputs return to reset values immediately. No partial sync pulse survives, and the frame restarts at (0,0).
- Out-of-range RGBIn or drawRequest during blanking is ignored, with no side effects.

Decomposition:
- Package defines gains:
  - H_*/V_* timing constants and H_TOTAL/V_TOTAL
  - COLOR_BACKGROUND
  - reuse of the existing COLOR_TRANSPARENT
  - a typedef for the 8-bit colour
- One sub-module: sync_delay_line, a parameterised WIDTH x DEPTH shift register with a per-bit async-reset value. It is instantiated once for {hSyncRaw, vSyncRaw, visible}.
- Counters and colour mux stay in the top module.

Test Plan:
1. Reset: hold resetN low 10 cycles with drawRequest=1 and RGBIn=8'hFF -> hSync=1, vSync=1, blankN=0, vgaRGB=0, pixelX=0, pixelY=0. Release -> pixelX increments 0,1,2,…
2. Line timing: run 3 lines with DRAW_LATENCY=1 -> pixelX wraps 799->0 and pixelY increments. hSync falls 2 cycles after pixelX=656, stays low exactly 96 cycles, and repeats every 800 cycles.
3. Frame timing: run 2 frames -> vSync low exactly 2×800 cycles, starting 2 cycles after (0,490). startOfFrame pulses once per 420000 cycles. blankN high for exactly 640×480 cycles per frame.
4. Colour alignment: drive drawRequest=1, RGBIn=8'hE0 only in the cycle after pixel (100,50) is presented -> vgaRGB=8'hE0 for exactly one cycle, 2 cycles after (100,50). Neighbouring pixels show COLOR_BACKGROUND.
5. Transparency/blanking: RGBIn=COLOR_TRANSPARENT with drawRequest=1 at (10,10) -> COLOR_BACKGROUND. drawRequest=1, RGBIn=8'h1C at (700,10) -> vgaRGB=0.
6. Reset mid-operation: assert resetN low at (300,491), during vSync -> vSync=1 and vgaRGB=0 immediately. After release, the frame restarts at (0,0) and startOfFrame pulses on the next cycle. Repeat tests 2 and 4 with DRAW_LATENCY=3; the output offset becomes 4 cycles.

Source files
------------

// File: rtl/vga_scan_controller_pkg.sv
// Shared raster timing, colour types and colour constants for the VGA scan path.
package vga_scan_controller_pkg;

    typedef logic [7:0]  color_t;   // RRRGGGBB
    typedef logic [10:0] coord_t;

    // 640x480@60 timing, in pixels (horizontal) and lines (vertical)
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Drawers return this colour for "see-through" pixels
    localparam color_t COLOR_TRANSPARENT = 8'hFF;
    // Shown wherever no drawer owns a visible pixel
    localparam color_t COLOR_BACKGROUND  = 8'h25;

endpackage

// File: rtl/vga_scan_controller_if.sv
// Draw bus between the scan controller and the object drawers, plus the VGA port.
interface vga_scan_controller_if;
    import vga_scan_controller_pkg::*;

    coord_t pixelX;
    coord_t pixelY;
    logic   drawRequest;
    color_t RGBIn;
    logic   startOfFrame;
    logic   hSync;
    logic   vSync;
    logic   blankN;
    color_t vgaRGB;

    modport master (
        output pixelX, pixelY, startOfFrame, hSync, vSync, blankN, vgaRGB,
        input  drawRequest, RGBIn
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, hSync, vSync, blankN, vgaRGB,
        output drawRequest, RGBIn
    );

endinterface

// File: rtl/vga_scan_controller_sync_delay_line.sv
// WIDTH x DEPTH shift register; every stage resets to RST_VAL so an idle
// pipeline presents inactive sync/visible levels.
module sync_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    // shift one stage per clock, clear to the inactive value on reset
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_stage <= {DEPTH{RST_VAL}};
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_controller.sv
// Raster counter and VGA output stage. Sync/blank decodes are delayed to meet
// the drawers' colour response, then everything is registered together.
module vga_scan_controller #(
    parameter int H_VISIBLE    = vga_scan_controller_pkg::H_VISIBLE,
    parameter int H_FRONT      = vga_scan_controller_pkg::H_FRONT,
    parameter int H_SYNC       = vga_scan_controller_pkg::H_SYNC,
    parameter int H_BACK       = vga_scan_controller_pkg::H_BACK,
    parameter int V_VISIBLE    = vga_scan_controller_pkg::V_VISIBLE,
    parameter int V_FRONT      = vga_scan_controller_pkg::V_FRONT,
    parameter int V_SYNC       = vga_scan_controller_pkg::V_SYNC,
    parameter int V_BACK       = vga_scan_controller_pkg::V_BACK,
    parameter int DRAW_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   resetN,
    vga_scan_controller_if.master  bus
);
    import vga_scan_controller_pkg::*;

    localparam int     HT       = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int     VT       = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam coord_t H_LAST   = coord_t'(HT - 1);
    localparam coord_t V_LAST   = coord_t'(VT - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    coord_t     r_hCount, r_vCount;
    logic       w_visible, w_hSyncRaw, w_vSyncRaw;
    logic       w_hSyncD, w_vSyncD, w_visibleD;
    color_t     w_color;
    logic       r_hSync, r_vSync, r_blankN, r_sof;
    color_t     r_vgaRGB;

    // raster counters: vCount advances and wraps on the hCount wrap edge
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hCount <= '0;
            r_vCount <= '0;
        end else if (r_hCount == H_LAST) begin
            r_hCount <= '0;
            r_vCount <= (r_vCount == V_LAST) ? '0 : r_vCount + 1'b1;
        end else begin
            r_hCount <= r_hCount + 1'b1;
        end
    end

    assign w_visible  = (r_hCount < H_VIS) && (r_vCount < V_VIS);
    assign w_hSyncRaw = !((r_hCount >= HS_START) && (r_hCount < HS_END));
    assign w_vSyncRaw = !((r_vCount >= VS_START) && (r_vCount < VS_END));

    sync_delay_line #(
        .WIDTH   (3),
        .DEPTH   (DRAW_LATENCY),
        .RST_VAL (3'b110)
    ) u_sync_delay (
        .clk    (clk),
        .resetN (resetN),
        .i_d    ({w_hSyncRaw, w_vSyncRaw, w_visible}),
        .o_q    ({w_hSyncD, w_vSyncD, w_visibleD})
    );

    // colour select: blanking forces black, transparent/unowned shows background
    always_comb begin
        w_color = '0;
        if (w_visibleD) begin
            if (bus.drawRequest && (bus.RGBIn != COLOR_TRANSPARENT))
                w_color = bus.RGBIn;
            else
                w_color = COLOR_BACKGROUND;
        end
    end

    // output register: sync, blank and colour leave together
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hSync  <= 1'b1;
            r_vSync  <= 1'b1;
            r_blankN <= 1'b0;
            r_vgaRGB <= '0;
            r_sof    <= 1'b0;
        end else begin
            r_hSync  <= w_hSyncD;
            r_vSync  <= w_vSyncD;
            r_blankN <= w_visibleD;
            r_vgaRGB <= w_color;
            r_sof    <= (r_hCount == '0) && (r_vCount == '0);
        end
    end

    assign bus.pixelX       = r_hCount;
    assign bus.pixelY       = r_vCount;
    assign bus.hSync        = r_hSync;
    assign bus.vSync        = r_vSync;
    assign bus.blankN       = r_blankN;
    assign bus.vgaRGB       = r_vgaRGB;
    assign bus.startOfFrame = r_sof;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Self-checking bench: a cycle-count reference model predicts every output.
module tb_vga_scan_controller;
    import vga_scan_controller_pkg::*;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, lat;
    } tcfg_t;

    localparam tcfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    localparam tcfg_t CFG_B = '{20, 4, 6, 5, 12, 2, 2, 3, 3};

    logic   clk = 1'b0;
    logic   rstA, rstB;
    logic   dr;
    color_t rgb;
    logic   sel;
    tcfg_t  cfg;
    int     k;
    int     checks = 0;
    int     errors = 0;

    vga_scan_controller_if ifA ();
    vga_scan_controller_if ifB ();

    assign ifA.drawRequest = dr;
    assign ifA.RGBIn       = rgb;
    assign ifB.drawRequest = dr;
    assign ifB.RGBIn       = rgb;

    vga_scan_controller #(.DRAW_LATENCY(1)) dutA (
        .clk    (clk),
        .resetN (rstA),
        .bus    (ifA)
    );

    vga_scan_controller #(
        .H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .DRAW_LATENCY(3)
    ) dutB (
        .clk    (clk),
        .resetN (rstB),
        .bus    (ifB)
    );

    always #20 clk = ~clk;

    logic [10:0] obs_x, obs_y;
    logic        obs_hs, obs_vs, obs_bl, obs_sof;
    color_t      obs_rgb;

    always_comb begin
        obs_x   = sel ? ifB.pixelX       : ifA.pixelX;
        obs_y   = sel ? ifB.pixelY       : ifA.pixelY;
        obs_hs  = sel ? ifB.hSync        : ifA.hSync;
        obs_vs  = sel ? ifB.vSync        : ifA.vSync;
        obs_bl  = sel ? ifB.blankN       : ifA.blankN;
        obs_rgb = sel ? ifB.vgaRGB       : ifA.vgaRGB;
        obs_sof = sel ? ifB.startOfFrame : ifA.startOfFrame;
    end

    // ---------------- reference model (cycle count n since reset release) ----
    function automatic int htot(tcfg_t c); return c.hv + c.hf + c.hs + c.hb; endfunction
    function automatic int vtot(tcfg_t c); return c.vv + c.vf + c.vs + c.vb; endfunction
    function automatic int px(tcfg_t c, int n); return n % htot(c); endfunction
    function automatic int py(tcfg_t c, int n); return (n / htot(c)) % vtot(c); endfunction

    // outputs after edge k describe the pixel shown lat+1 edges earlier
    function automatic logic m_hs(tcfg_t c, int kk);
        int x;
        if (kk < c.lat + 1) return 1'b1;
        x = px(c, kk - c.lat - 1);
        return !(x >= c.hv + c.hf && x < c.hv + c.hf + c.hs);
    endfunction

    function automatic logic m_vs(tcfg_t c, int kk);
        int y;
        if (kk < c.lat + 1) return 1'b1;
        y = py(c, kk - c.lat - 1);
        return !(y >= c.vv + c.vf && y < c.vv + c.vf + c.vs);
    endfunction

    function automatic logic m_vis(tcfg_t c, int kk);
        if (kk < c.lat + 1) return 1'b0;
        return px(c, kk - c.lat - 1) < c.hv && py(c, kk - c.lat - 1) < c.vv;
    endfunction

    // d/r are the inputs presented in the cycle before edge k
    function automatic color_t m_rgb(tcfg_t c, int kk, logic d, color_t r);
        if (!m_vis(c, kk)) return 8'h00;
        if (d && r != COLOR_TRANSPARENT) return r;
        return COLOR_BACKGROUND;
    endfunction

    function automatic logic m_sof(tcfg_t c, int kk);
        return kk >= 1 && ((kk - 1) % (htot(c) * vtot(c))) == 0;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s k=%0d: observed %0h expected %0h", tag, k, o, e);
        end
    endtask

    task automatic check_cycle();
        chk("pixelX",  32'(obs_x),   32'(px(cfg, k)));
        chk("pixelY",  32'(obs_y),   32'(py(cfg, k)));
        chk("hSync",   32'(obs_hs),  32'(m_hs(cfg, k)));
        chk("vSync",   32'(obs_vs),  32'(m_vs(cfg, k)));
        chk("blankN",  32'(obs_bl),  32'(m_vis(cfg, k)));
        chk("vgaRGB",  32'(obs_rgb), 32'(m_rgb(cfg, k, dr, rgb)));
        chk("sof",     32'(obs_sof), 32'(m_sof(cfg, k)));
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_x"},   32'(obs_x),   32'd0);
        chk({tag, "_y"},   32'(obs_y),   32'd0);
        chk({tag, "_hs"},  32'(obs_hs),  32'd1);
        chk({tag, "_vs"},  32'(obs_vs),  32'd1);
        chk({tag, "_bl"},  32'(obs_bl),  32'd0);
        chk({tag, "_rgb"}, 32'(obs_rgb), 32'd0);
        chk({tag, "_sof"}, 32'(obs_sof), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        check_cycle();
    endtask

    task automatic rand_in();
        dr  = 1'($urandom);
        rgb = ($urandom_range(0, 3) == 0) ? COLOR_TRANSPARENT : 8'($urandom);
    endtask

    int hs_low, bl_cnt, vs_low, hs_lowB, sof_cnt;
    bit found;

    initial begin
        sel = 1'b0; cfg = CFG_A; k = 0;
        rstA = 1'b0; rstB = 1'b0;
        dr = 1'b1; rgb = 8'hFF;
        hs_low = 0; bl_cnt = 0; vs_low = 0; hs_lowB = 0; sof_cnt = 0;

        // reset hold with an active, opaque-looking draw request
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk_reset("rstA");
        end
        rstA = 1'b1; k = 0;
        rand_in();
        check_cycle();

        // DUT A: full 640x480 timing, latency 1
        for (int i = 0; i < 40110; i++) begin
            step();
            if (k == 1)     chk("A_sof_first",  32'(obs_sof), 32'd1);
            if (k == 2)     chk("A_x_inc",      32'(obs_x),   32'd2);
            if (k == 657)   chk("A_hs_before",  32'(obs_hs),  32'd1);
            if (k == 658)   chk("A_hs_fall",    32'(obs_hs),  32'd0);
            if (k == 753)   chk("A_hs_last",    32'(obs_hs),  32'd0);
            if (k == 754)   chk("A_hs_rise",    32'(obs_hs),  32'd1);
            if (k == 799)   chk("A_x_799",      32'(obs_x),   32'd799);
            if (k == 800) begin
                chk("A_x_wrap", 32'(obs_x), 32'd0);
                chk("A_y_inc",  32'(obs_y), 32'd1);
            end
            if (k == 8012)  chk("A_transp_bg",  32'(obs_rgb), 32'(COLOR_BACKGROUND));
            if (k == 8702)  chk("A_blank_rgb",  32'(obs_rgb), 32'd0);
            if (k == 40101) chk("A_left_bg",    32'(obs_rgb), 32'(COLOR_BACKGROUND));
            if (k == 40102) chk("A_pixel_e0",   32'(obs_rgb), 32'hE0);
            if (k == 40103) chk("A_right_bg",   32'(obs_rgb), 32'(COLOR_BACKGROUND));
            if (k >= 2 && k < 802 && obs_hs == 1'b0) hs_low++;
            // inputs for cycle k
            if (k < 2500) rand_in();
            else begin dr = 1'b0; rgb = 8'($urandom); end
            if (k == 8010 + 1)  begin dr = 1'b1; rgb = COLOR_TRANSPARENT; end
            if (k == 8700 + 1)  begin dr = 1'b1; rgb = 8'h1C; end
            if (k == 40100 + 1) begin dr = 1'b1; rgb = 8'hE0; end
        end
        chk("A_hs_width", 32'(hs_low), 32'd96);

        // DUT B: reduced timing (35x19), latency 3
        sel = 1'b1; cfg = CFG_B;
        dr = 1'b1; rgb = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_reset("rstB");
        end
        rstB = 1'b1; k = 0;
        rand_in();
        check_cycle();
        for (int i = 0; i < 2100; i++) begin
            step();
            if (k == 1)   chk("B_sof_first", 32'(obs_sof), 32'd1);
            if (k == 76)  chk("B_transp_bg", 32'(obs_rgb), 32'(COLOR_BACKGROUND));
            if (k == 99)  chk("B_blank_rgb", 32'(obs_rgb), 32'd0);
            if (k == 113) chk("B_left_bg",   32'(obs_rgb), 32'(COLOR_BACKGROUND));
            if (k == 114) chk("B_pixel_e0",  32'(obs_rgb), 32'hE0);
            if (k == 115) chk("B_right_bg",  32'(obs_rgb), 32'(COLOR_BACKGROUND));
            if (k >= 669 && k < 1334) begin
                if (obs_bl)        bl_cnt++;
                if (!obs_vs)       vs_low++;
                if (!obs_hs)       hs_lowB++;
                if (obs_sof)       sof_cnt++;
            end
            if (k >= 60 && k <= 130) begin dr = 1'b0; rgb = 8'($urandom); end
            else rand_in();
            if (k == 72 + 3)  begin dr = 1'b1; rgb = COLOR_TRANSPARENT; end
            if (k == 95 + 3)  begin dr = 1'b1; rgb = 8'h1C; end
            if (k == 110 + 3) begin dr = 1'b1; rgb = 8'hE0; end
        end
        chk("B_blank_cnt", 32'(bl_cnt),  32'd240);
        chk("B_vs_low",    32'(vs_low),  32'd70);
        chk("B_hs_low",    32'(hs_lowB), 32'd114);
        chk("B_sof_cnt",   32'(sof_cnt), 32'd1);

        // advance to pixel (10,14), inside vSync, then reset mid-frame
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            step();
            rand_in();
            if (px(cfg, k) == 10 && py(cfg, k) == 14) found = 1'b1;
        end
        chk("B_rst_point", 32'(found), 32'd1);
        chk("B_vs_before_rst", 32'(obs_vs), 32'd0);
        rstB = 1'b0;
        #1;
        chk_reset("midrst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_reset("midrst_hold");
        end
        rstB = 1'b1; k = 0;
        rand_in();
        check_cycle();
        for (int i = 0; i < 700; i++) begin
            step();
            if (k == 1) chk("B_sof_restart", 32'(obs_sof), 32'd1);
            rand_in();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
